char_strobe_tx: RTL and testbench



---
 rtl/char_strobe_tx.sv | 177 +++++++++++++++++
 tb/tb_char_strobe_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_strobe_tx.sv
// char_strobe_tx: FIFO-buffered producer end of the Apple-1 DA/RDA display handshake.
// Defining CHAR_STROBE_TX_TIMEOUT_EN adds an RDA-stuck timeout with a sticky err flag.
module char_strobe_tx #(
    parameter int DEPTH   = 16,
    parameter int DA_MIN  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   cp,
    input  logic                   mr,
    input  logic                   wr_en,
    input  logic [6:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic [6:0]             dout,
    output logic                   da,
    input  logic                   rda,
    output logic                   busy,
    output logic                   err
);
    // state     | meaning
    // ST_IDLE   | no transfer; pop when a character is queued and rda_s=1
    // ST_STROBE | da high; leave once DA_MIN is met and rda_s=0
    // ST_WAIT   | da low; wait for the terminal to raise rda_s again
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] DA_LAST = SW'(DA_MIN - 1);
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
    localparam logic [SW-1:0] TO_LAST = SW'(TIMEOUT - 1);
    localparam logic [SW-1:0] CNT_SAT = TO_LAST;
`else
    localparam logic [SW-1:0] CNT_SAT = DA_LAST;
`endif

    logic [6:0]    mem_q [DEPTH];
    logic [6:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [6:0]    dout_q, dout_d;
    logic          da_q, da_d;
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          rda_meta_q, rda_s_q;
    logic          push, pop;
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
    logic          err_q, err_d;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;

    always_comb begin
        state_d = state_q;
        da_d    = da_q;
        dout_d  = dout_q;
        scnt_d  = scnt_q;
        pop     = 1'b0;
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty && rda_s_q) begin
                    pop     = 1'b1;
                    dout_d  = mem_q[rd_ptr_q];
                    da_d    = 1'b1;
                    scnt_d  = '0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (scnt_q >= DA_LAST && !rda_s_q) begin
                    da_d    = 1'b0;
                    state_d = ST_WAIT;
                end
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
                // terminal never took the character: drop it, rda_s is already high
                else if (scnt_q == TO_LAST && rda_s_q) begin
                    da_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
                if (scnt_q != CNT_SAT) begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_WAIT: begin
                if (rda_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                da_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge cp) begin
        if (mr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
            da_q       <= 1'b0;
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            rda_meta_q <= 1'b0;
            rda_s_q    <= 1'b0;
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            da_q       <= da_d;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            rda_meta_q <= rda;
            rda_s_q    <= rda_meta_q;
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    // storage needs no reset: the pointers define which entries are live
    always_ff @(posedge cp) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign dout  = dout_q;
    assign da    = da_q;
    assign busy  = (state_q != ST_IDLE);
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_char_strobe_tx.sv
// Self-checking bench for char_strobe_tx: vector table, directed handshake sequences,
// and randomized traffic compared each cycle against a queue-based reference model.
module tb_char_strobe_tx;
    localparam int DEPTH   = 16;
    localparam int DA_MIN  = 4;
    localparam int TIMEOUT = 32;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          cp = 1'b0;
    logic          mr = 1'b1;
    logic          wr_en = 1'b0;
    logic [6:0]    wr_data = '0;
    logic          rda = 1'b0;
    logic          full, empty, ovf, da, busy, err;
    logic [CW-1:0] count;
    logic [6:0]    dout;

    char_strobe_tx #(.DEPTH(DEPTH), .DA_MIN(DA_MIN), .TIMEOUT(TIMEOUT)) dut (
        .cp(cp), .mr(mr), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf),
        .dout(dout), .da(da), .rda(rda), .busy(busy), .err(err)
    );

    always #5 cp = ~cp;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    // Reference model: a character queue plus the handshake rules in terms of
    // "how long has da been high" and "are we waiting for the terminal".
    int         mq[$];
    bit         m_ovf, m_da, m_wait, m_err, m_meta, m_rs;
    int         m_hi;
    logic [6:0] m_dout;

    task automatic model_step();
        bit was_full, rs;
        if (mr) begin
            mq.delete();
            m_ovf = 0; m_da = 0; m_wait = 0; m_err = 0;
            m_meta = 0; m_rs = 0; m_hi = 0; m_dout = '0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        rs = m_rs;
        if (m_da) begin
            if (m_hi >= DA_MIN && !rs) begin
                m_da = 0; m_wait = 1;
            end
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
            else if (m_hi >= TIMEOUT && rs) begin
                m_da = 0; m_err = 1;
            end
`endif
            else m_hi++;
        end else if (m_wait) begin
            if (rs) m_wait = 0;
        end else if (mq.size() > 0 && rs) begin
            m_dout = 7'(mq.pop_front());
            m_da = 1;
            m_hi = 1;
        end
        if (wr_en) begin
            if (was_full) m_ovf = 1;
            else mq.push_back(int'(wr_data));
        end
        m_rs = m_meta;
        m_meta = rda;
    endtask

    initial forever begin
        @(posedge cp);
        model_step();
    end

    initial forever begin
        @(negedge cp);
        if (chk_en)
            chk("model", {count, empty, full, ovf, da, busy, err, dout},
                {CW'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_ovf, m_da,
                 m_da || m_wait, m_err, m_dout});
    end

    // characters seen by the terminal latch, captured on each da rise
    logic [6:0] got[$];
    bit da_prev = 1'b0;
    initial forever begin
        @(negedge cp);
        if (da === 1'b1 && !da_prev) got.push_back(dout);
        da_prev = (da === 1'b1);
    end

    typedef struct {
        bit         mr;
        bit         we;
        logic [6:0] d;
        int         e_count;
        bit         e_empty;
        bit         e_full;
        bit         e_ovf;
        bit         e_da;
        logic [6:0] e_dout;
    } vec_t;

    vec_t tbl[8];

    task automatic do_reset();
        mr = 1'b1; wr_en = 1'b0;
        tick();
        mr = 1'b0;
    endtask

    task automatic push_now(input logic [6:0] c);
        wr_en = 1'b1; wr_data = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int want);
        int budget = 800;
        while ((got.size() < want || busy) && budget > 0) begin
            rda = !da;
            tick();
            budget--;
        end
        chk("drain_done", 32'(budget > 0), 1);
    endtask

    task automatic push_paced(input logic [6:0] c);
        int budget = 400;
        while (full && budget > 0) begin
            rda = !da;
            tick();
            budget--;
        end
        chk("push_wait", 32'(budget > 0), 1);
        wr_en = 1'b1; wr_data = c; rda = !da;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int len, idle_at, fall_n;
        bit da33;
        logic [6:0] dout33;
        int p;

        // reset with wr_en held high, then pushes with rda low (nothing pops)
        tbl[0] = '{1, 1, 7'h11, 0, 1, 0, 0, 0, 7'h00};
        tbl[1] = '{1, 1, 7'h12, 0, 1, 0, 0, 0, 7'h00};
        tbl[2] = '{0, 1, 7'h41, 1, 0, 0, 0, 0, 7'h00};
        tbl[3] = '{0, 0, 7'h00, 1, 0, 0, 0, 0, 7'h00};
        tbl[4] = '{0, 1, 7'h42, 2, 0, 0, 0, 0, 7'h00};
        tbl[5] = '{0, 1, 7'h43, 3, 0, 0, 0, 0, 7'h00};
        tbl[6] = '{1, 1, 7'h44, 0, 1, 0, 0, 0, 7'h00};
        tbl[7] = '{0, 0, 7'h00, 0, 1, 0, 0, 0, 7'h00};

        rda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mr = tbl[i].mr; wr_en = tbl[i].we; wr_data = tbl[i].d;
            if (i >= 2) rda = 1'b0;
            tick();
            chk_en = 1'b1;
            chk($sformatf("vec%0d", i), {count, empty, full, ovf, da, err, dout},
                {CW'(tbl[i].e_count), tbl[i].e_empty, tbl[i].e_full, tbl[i].e_ovf,
                 tbl[i].e_da, 1'b0, tbl[i].e_dout});
        end
        wr_en = 1'b0; mr = 1'b0;

        // single transfer: terminal drops rda 3 cycles after da rises, raises it 5 later
        do_reset();
        rda = 1'b1;
        repeat (3) tick();
        push_now(7'h41);
        tick();
        chk("t2_latency_da", 32'(da), 1);
        chk("t2_dout", 32'(dout), 32'h41);
        len = 0; idle_at = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (!da && len == 0) len = n;
            if (!busy && idle_at == 0) idle_at = n;
            if (n == 3) rda = 1'b0;
            if (n == 8) rda = 1'b1;
        end
        chk("t2_da_high_len", 32'(len), 6);
        chk("t2_busy_until", 32'(idle_at), 11);
        chk("t2_empty", 32'(empty), 1);

        // ordering: fill with rda low, then drain, then 20 more across pointer wrap
        do_reset();
        rda = 1'b0;
        for (int i = 0; i < 16; i++) push_now(7'(32'h30 + i));
        chk("t3_full", 32'(full), 1);
        chk("t3_count", 32'(count), 16);
        got.delete();
        drain(16);
        chk("t3_got_n", 32'(got.size()), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("t3_order%0d", i), 32'(got[i]), 32'h30 + i);
        got.delete();
        for (int i = 0; i < 20; i++) push_paced(7'(32'h40 + i));
        drain(20);
        chk("t3_wrap_n", 32'(got.size()), 20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            chk($sformatf("t3_wrap%0d", i), 32'(got[i]), 32'h40 + i);

        // overflow: the 17th push is dropped and never reaches the terminal
        do_reset();
        rda = 1'b0;
        for (int i = 0; i < 16; i++) push_now(7'(32'h60 + i));
        push_now(7'h7F);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_count", 32'(count), 16);
        got.delete();
        drain(16);
        chk("t4_got_n", 32'(got.size()), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("t4_order%0d", i), 32'(got[i]), 32'h60 + i);
        chk("t4_ovf_sticky", 32'(ovf), 1);

        // fast terminal: rda drops as soon as da rises; da must still last DA_MIN
        do_reset();
        rda = 1'b1;
        repeat (3) tick();
        push_now(7'h22);
        tick();
        chk("t5_da_up", 32'(da), 1);
        rda = 1'b0;
        len = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (!da && len == 0) len = n;
        end
        chk("t5_da_high_len", 32'(len), DA_MIN);
        rda = 1'b1;
        repeat (4) tick();

        // stuck terminal: rda never falls
        do_reset();
        rda = 1'b1;
        repeat (3) tick();
        push_now(7'h55);
        push_now(7'h56);
        chk("t6_da_up", 32'(da), 1);
        chk("t6_dout", 32'(dout), 32'h55);
        fall_n = 0; da33 = 0; dout33 = '0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (!da && fall_n == 0) fall_n = n;
            if (n == 33) begin da33 = da; dout33 = dout; end
        end
`ifdef CHAR_STROBE_TX_TIMEOUT_EN
        chk("t6_timeout_at", 32'(fall_n), TIMEOUT);
        chk("t6_next_da", 32'(da33), 1);
        chk("t6_next_dout", 32'(dout33), 32'h56);
        chk("t6_err", 32'(err), 1);
`else
        chk("t6_no_fall", 32'(fall_n), 0);
        chk("t6_da_held", 32'(da), 1);
        chk("t6_err", 32'(err), 0);
`endif

        // reset while strobing
        do_reset();
        rda = 1'b1;
        repeat (3) tick();
        push_now(7'h12);
        push_now(7'h13);
        tick();
        chk("t7_in_strobe", 32'(da), 1);
        mr = 1'b1;
        tick();
        chk("t7_reset", {da, empty, busy, count}, {1'b0, 1'b1, 1'b0, CW'(0)});
        mr = 1'b0;

        // randomized traffic, checked every cycle by the model
        p = 6;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 2;
                    1: p = 8;
                    default: p = 60;
                endcase
            end
            mr = ($urandom_range(0, 499) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            wr_data = 7'($urandom);
            if ($urandom_range(0, p - 1) == 0) rda = !rda;
            tick();
        end
        mr = 1'b0; wr_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
